rx_frame_sequencer: RTL and testbench
=====================================

RX_FRAME_SEQUENCER -- requirements
Module: rx_frame_sequencer

Interface
REQ-001 Parameters SHALL be:
- PREAMBLE_LEN, 12: consecutive 1-bits that mark sync.
- MAX_LEN, 4095: largest accepted LENGTH in bytes (1..4095).

REQ-002 Ports SHALL be (clock and reset first):
- Clk  in  1  clock; all logic on posedge.
- Reset  in  1  synchronous, active-high.
- En  in  1  enable; low acts as a soft reset to IDLE.
- Data  in  1  received serial bit.
- Data_valid  in  1  Data qualifier.
- Descr_data  in  1  descrambler output bit, valid the same cycle as Descr_en.
- Descr_en  out  1  descrambler advance strobe.
- Descr_load  out  1  one-cycle seed-load strobe.
- Descr_seed  out  7  seed for Descr_load.
- Out  out  1  payload bit.
- Out_valid  out  1  Out qualifier.
- Rate  out  4  decoded SIGNAL RATE.
- Length  out  12  decoded SIGNAL LENGTH.
- Signal_err  out  1  one-cycle SIGNAL reject pulse.
- Frame_done  out  1  one-cycle end-of-frame pulse.
- Busy  out  1  high in every state except IDLE.

Function
REQ-003 The FSM SHALL have states IDLE, PREAMBLE, SIGNAL, SERVICE, PAYLOAD, TAIL.

REQ-004 The FSM SHALL advance, and counters SHALL change, only on cycles with Data_valid=1; cycles with Data_valid=0 freeze all state and deassert all strobes.

REQ-005 IDLE SHALL move to PREAMBLE on the first valid cycle with En=1.

REQ-006 In PREAMBLE:
- each valid Data=1 increments a run counter; Data=0 clears it.
- on the valid cycle where the count reaches PREAMBLE_LEN, go to SIGNAL.

REQ-007 In SIGNAL, 24 valid bits SHALL be shifted in LSB-first as bit0..bit23:
- RATE = bits 0-3; reserved = bit 4; LENGTH = bits 5-16 (LSB first); parity = bit 17; tail = bits 18-23.

REQ-008 After bit 23 the SIGNAL field SHALL be rejected if any of these holds:
- even parity over bits 0-17 fails;
- reserved bit = 1;
- RATE bit 3 = 0;
- LENGTH = 0;
- LENGTH > MAX_LEN.

REQ-009 On reject: Signal_err pulses 1 cycle, the FSM returns to PREAMBLE with the run counter cleared, and Rate/Length keep their previous values.

REQ-010 On accept: Rate and Length SHALL be registered and held until the next accepted SIGNAL or reset, and the FSM goes to SERVICE.

REQ-011 In SERVICE, the first 7 valid bits SHALL be captured LSB-first into Descr_seed. On the 7th bit, Descr_load pulses 1 cycle together with the final Descr_seed value.

REQ-012 Service bits 8-16 SHALL assert Descr_en with Out_valid=0. After the 16th service bit the FSM goes to PAYLOAD.

REQ-013 In PAYLOAD:
- Descr_en = Data_valid;
- Out <= Descr_data and Out_valid <= 1, registered, giving 1-cycle latency from the input bit to Out;
- exactly 8*Length bits are emitted, counted by a 15-bit counter; then go to TAIL.

REQ-014 In TAIL, 6 valid bits SHALL be consumed with Descr_en=0. After the 6th bit, Frame_done pulses 1 cycle and the FSM goes to IDLE.

REQ-015 Out_valid SHALL be 0 in every cycle that does not follow a valid PAYLOAD input cycle; Out SHALL be 0 whenever Out_valid=0.

REQ-016 If En deasserts in any state, the next clock SHALL force IDLE, clear all counters and strobes, and drop any partial frame without Frame_done. Rate and Length are held.

REQ-017 Descr_load and Descr_en SHALL never be high in the same cycle.

Reset
REQ-018 On Reset=1 at a clock edge:
- state = IDLE; all counters = 0;
- Descr_en, Descr_load, Out, Out_valid, Signal_err, Frame_done, Busy = 0;
- Descr_seed = 7'h00, Rate = 4'h0, Length = 12'h000.

REQ-019 Reset SHALL take priority over En and Data_valid.

Configuration
REQ-020 With macro RX_SIGNAL_TAIL_CHECK_EN defined, SIGNAL tail bits 18-23 not all zero SHALL be an additional reject cause under REQ-008. Without the macro, tail bits SHALL be ignored.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Preamble of 12 ones; SIGNAL RATE=4'b1101, LENGTH=3, correct parity; service seed 7'b1011101; 24 payload bits -> Descr_load pulses once with seed 7'h5D, exactly 24 Out_valid cycles, then Frame_done after 6 tail bits.
- Same frame with the parity bit flipped -> Signal_err pulse, no Descr_load, Rate/Length unchanged, FSM back in PREAMBLE.
- Preamble run broken at bit 11 by a 0, then 12 ones -> SIGNAL entered only after the second run.
- Data_valid toggling 1/0 every cycle across the whole frame -> same Out sequence as with continuous valid, only stretched in time.
- En dropped mid-PAYLOAD after 10 bits -> IDLE on the next clock, Out_valid=0, no Frame_done.
- With RX_SIGNAL_TAIL_CHECK_EN defined and SIGNAL tail = 6'b000001 -> Signal_err. Without the macro, the same frame is accepted.

Source files
------------

// File: rtl/rx_frame_sequencer.sv
// rx_frame_sequencer: serial receive-frame sequencer.
// Finds a run of PREAMBLE_LEN ones, decodes and validates the 24-bit SIGNAL
// field, loads the descrambler seed from the first 7 SERVICE bits, streams
// 8*Length descrambled payload bits to Out and consumes the 6-bit TAIL.
// Optional build macro: RX_SIGNAL_TAIL_CHECK_EN -- when defined, a SIGNAL
// field whose tail bits 18-23 are not all zero is rejected as well.
module rx_frame_sequencer #(
  parameter int PREAMBLE_LEN = 12,
  parameter int MAX_LEN      = 4095
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        En,
  input  logic        Data,
  input  logic        Data_valid,
  input  logic        Descr_data,
  output logic        Descr_en,
  output logic        Descr_load,
  output logic [6:0]  Descr_seed,
  output logic        Out,
  output logic        Out_valid,
  output logic [3:0]  Rate,
  output logic [11:0] Length,
  output logic        Signal_err,
  output logic        Frame_done,
  output logic        Busy
);

  localparam int RUN_W = $clog2(PREAMBLE_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_SIGNAL, S_SERVICE, S_PAYLOAD, S_TAIL
  } state_t;

  state_t           state, state_nxt;
  logic [RUN_W-1:0] run_cnt;
  logic [14:0]      bit_cnt;
  logic [23:0]      sig_sr;
  logic [6:0]       seed_r;
  logic [3:0]       rate_r;
  logic [11:0]      length_r;
  logic             out_p1;
  logic             vld_p1;
  logic             sig_err_r;
  logic             frame_done_r;

  logic             adv;
  logic [23:0]      sig_word;
  logic             preamble_hit;
  logic             sig_last;
  logic             sig_pass;
  logic             svc_last;
  logic             pay_last;
  logic             tail_last;
  logic [14:0]      pay_end;

  // SIGNAL acceptance: even parity over bits 0-17, reserved clear, RATE bit 3
  // set, LENGTH within 1..MAX_LEN (and tail clear when the check is built in).
  function automatic logic sig_ok(input logic [23:0] f);
    logic ok;
    ok = 1'b1;
    if (^f[17:0])                             ok = 1'b0;
    if (f[4])                                 ok = 1'b0;
    if (!f[3])                                ok = 1'b0;
    if (f[16:5] == 12'd0)                     ok = 1'b0;
    if ({20'd0, f[16:5]} > 32'(MAX_LEN))      ok = 1'b0;
`ifdef RX_SIGNAL_TAIL_CHECK_EN
    if (f[23:18] != 6'd0)                     ok = 1'b0;
`else
`endif
    return ok;
  endfunction

  assign adv          = En & Data_valid;
  assign sig_word     = {Data, sig_sr[23:1]};
  assign preamble_hit = Data && (run_cnt == RUN_W'(PREAMBLE_LEN - 1));
  assign sig_last     = (bit_cnt == 15'd23);
  assign sig_pass     = sig_ok(sig_word);
  assign svc_last     = (bit_cnt == 15'd15);
  assign pay_end      = {length_r, 3'b000} - 15'd1;
  assign pay_last     = (bit_cnt == pay_end);
  assign tail_last    = (bit_cnt == 15'd5);

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: advance only on valid input bits; En low forces IDLE.
  always_comb begin
    state_nxt = state;
    if (!En) begin
      state_nxt = S_IDLE;
    end else if (Data_valid) begin
      case (state)
        S_IDLE:     state_nxt = S_PREAMBLE;
        S_PREAMBLE: if (preamble_hit) state_nxt = S_SIGNAL;
        S_SIGNAL:   if (sig_last) state_nxt = sig_pass ? S_SERVICE : S_PREAMBLE;
        S_SERVICE:  if (svc_last) state_nxt = S_PAYLOAD;
        S_PAYLOAD:  if (pay_last) state_nxt = S_TAIL;
        S_TAIL:     if (tail_last) state_nxt = S_IDLE;
        default:    state_nxt = S_IDLE;
      endcase
    end
  end

  // Counters, field capture and registered pulses / payload output.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      run_cnt      <= '0;
      bit_cnt      <= '0;
      sig_sr       <= '0;
      seed_r       <= '0;
      rate_r       <= '0;
      length_r     <= '0;
      out_p1       <= 1'b0;
      vld_p1       <= 1'b0;
      sig_err_r    <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      sig_err_r    <= 1'b0;
      frame_done_r <= 1'b0;
      out_p1       <= 1'b0;
      vld_p1       <= 1'b0;
      if (!En) begin
        run_cnt <= '0;
        bit_cnt <= '0;
      end else if (Data_valid) begin
        case (state)
          S_IDLE: begin
            run_cnt <= '0;
            bit_cnt <= '0;
          end
          S_PREAMBLE: begin
            bit_cnt <= '0;
            if (preamble_hit) run_cnt <= '0;
            else if (Data)    run_cnt <= run_cnt + RUN_W'(1);
            else              run_cnt <= '0;
          end
          S_SIGNAL: begin
            sig_sr <= sig_word;
            if (sig_last) begin
              bit_cnt <= '0;
              if (sig_pass) begin
                rate_r   <= sig_word[3:0];
                length_r <= sig_word[16:5];
              end else begin
                sig_err_r <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 15'd1;
            end
          end
          S_SERVICE: begin
            if (bit_cnt < 15'd7) seed_r <= {Data, seed_r[6:1]};
            bit_cnt <= svc_last ? 15'd0 : bit_cnt + 15'd1;
          end
          S_PAYLOAD: begin
            // Stage p1: one-cycle registered payload bit
            out_p1  <= Descr_data;
            vld_p1  <= 1'b1;
            bit_cnt <= pay_last ? 15'd0 : bit_cnt + 15'd1;
          end
          S_TAIL: begin
            if (tail_last) begin
              frame_done_r <= 1'b1;
              bit_cnt      <= '0;
            end else begin
              bit_cnt <= bit_cnt + 15'd1;
            end
          end
          default: bit_cnt <= '0;
        endcase
      end
    end
  end

  // Output decode: descrambler strobes are same-cycle with the input bit.
  always_comb begin
    Busy       = (state != S_IDLE);
    Descr_load = adv && (state == S_SERVICE) && (bit_cnt == 15'd6);
    Descr_en   = adv && (((state == S_SERVICE) && (bit_cnt >= 15'd7)) ||
                         (state == S_PAYLOAD));
    Descr_seed = Descr_load ? {Data, seed_r[6:1]} : seed_r;
    Out        = out_p1;
    Out_valid  = vld_p1;
    Rate       = rate_r;
    Length     = length_r;
    Signal_err = sig_err_r;
    Frame_done = frame_done_r;
  end

endmodule

// File: tb/tb_rx_frame_sequencer.sv
// Testbench for rx_frame_sequencer: directed frames, scoreboard on Out.
module tb_rx_frame_sequencer;

  logic        Clk = 1'b0;
  logic        Reset, En, Data, Data_valid, Descr_data;
  logic        Descr_en, Descr_load, Out, Out_valid, Signal_err, Frame_done, Busy;
  logic [6:0]  Descr_seed;
  logic [3:0]  Rate;
  logic [11:0] Length;

  rx_frame_sequencer dut (
    .Clk(Clk), .Reset(Reset), .En(En), .Data(Data), .Data_valid(Data_valid),
    .Descr_data(Descr_data), .Descr_en(Descr_en), .Descr_load(Descr_load),
    .Descr_seed(Descr_seed), .Out(Out), .Out_valid(Out_valid), .Rate(Rate),
    .Length(Length), .Signal_err(Signal_err), .Frame_done(Frame_done), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  int   pass_cnt = 0;
  int   total_cnt = 0;
  logic exp_q[$];
  int   load_cnt = 0, err_cnt = 0, done_cnt = 0, ov_cnt = 0, den_cnt = 0;
  logic [6:0]  seed_at_load = 7'h00;
  logic [3:0]  exp_rate = 4'h0;
  logic [11:0] exp_len = 12'h000;
  logic [23:0] pat = 24'hA5C36E;

  task automatic chk(input string nm, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Monitor / scoreboard
  initial begin
    forever begin
      @(negedge Clk);
      if (!Reset) begin
        chk("load_en_exclusive", int'(Descr_load & Descr_en), 0);
        if (Out_valid) begin
          ov_cnt++;
          if (exp_q.size() == 0) chk("out_unexpected", 1, 0);
          else chk("out_bit", int'(Out), int'(exp_q.pop_front()));
        end else begin
          chk("out_zero_when_invalid", int'(Out), 0);
        end
        if (Descr_load) begin load_cnt++; seed_at_load = Descr_seed; end
        if (Descr_en)   den_cnt++;
        if (Signal_err) err_cnt++;
        if (Frame_done) done_cnt++;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic d, input logic dd, input bit gap);
    Data = d; Descr_data = dd; Data_valid = 1'b1;
    @(posedge Clk); #1;
    if (gap) begin
      Data = ~d; Descr_data = ~dd; Data_valid = 1'b0;
      @(posedge Clk); #1;
    end
  endtask

  task automatic idle(input int n);
    Data_valid = 1'b0; Data = 1'b0; Descr_data = 1'b0;
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic run_frame(input string nm, input logic [3:0] rate, input logic [11:0] len,
                           input bit flip, input bit res, input logic [5:0] tail,
                           input logic [6:0] seed, input bit gap, input bit brk,
                           input int abort_at, input bit ok);
    logic [23:0] sig;
    int b_load, b_err, b_done, b_ov, b_den, npay;
    bit aborted;
    b_load = load_cnt; b_err = err_cnt; b_done = done_cnt; b_ov = ov_cnt; b_den = den_cnt;
    aborted = 0;
    sig = {tail, 1'b0, len, res, rate};
    sig[17] = (^sig[16:0]) ^ flip;
    drive(1'b0, 1'b0, gap);
    drive(1'b0, 1'b0, gap);
    if (brk) begin
      for (int i = 0; i < 11; i++) drive(1'b1, 1'b1, gap);
      drive(1'b0, 1'b0, gap);
    end
    for (int i = 0; i < 12; i++) drive(1'b1, 1'b1, gap);
    for (int i = 0; i < 24; i++) drive(sig[i], sig[i], gap);
    if (ok) begin
      for (int i = 0; i < 7; i++) drive(seed[i], seed[i], gap);
      for (int i = 0; i < 9; i++) drive(1'b0, 1'b0, gap);
      npay = int'(len) * 8;
      for (int i = 0; i < npay; i++) begin
        if (i == abort_at) begin aborted = 1; break; end
        exp_q.push_back(pat[i % 24]);
        drive(~pat[i % 24], pat[i % 24], gap);
      end
      if (aborted) begin
        En = 1'b0; Data_valid = 1'b1; Data = 1'b1;
        @(posedge Clk); #1;
        chk({nm, "_abort_busy"}, int'(Busy), 0);
        chk({nm, "_abort_out_valid"}, int'(Out_valid), 0);
        idle(2);
        En = 1'b1;
        idle(3);
      end else begin
        for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, gap);
      end
      idle(3);
      exp_rate = rate; exp_len = len;
      chk({nm, "_load_count"}, load_cnt - b_load, 1);
      chk({nm, "_seed"}, int'(seed_at_load), int'(seed));
      chk({nm, "_out_valid_count"}, ov_cnt - b_ov, aborted ? abort_at : npay);
      chk({nm, "_descr_en_count"}, den_cnt - b_den, 9 + (aborted ? abort_at : npay));
      chk({nm, "_frame_done"}, done_cnt - b_done, aborted ? 0 : 1);
      chk({nm, "_busy"}, int'(Busy), 0);
    end else begin
      idle(3);
      chk({nm, "_load_count"}, load_cnt - b_load, 0);
      chk({nm, "_out_valid_count"}, ov_cnt - b_ov, 0);
      chk({nm, "_busy_preamble"}, int'(Busy), 1);
    end
    chk({nm, "_signal_err"}, err_cnt - b_err, ok ? 0 : 1);
    chk({nm, "_rate"}, int'(Rate), int'(exp_rate));
    chk({nm, "_length"}, int'(Length), int'(exp_len));
    chk({nm, "_queue_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    bit tail_ok;
    Reset = 1'b1; En = 1'b1; Data = 1'b1; Data_valid = 1'b1; Descr_data = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b0; Data_valid = 1'b0;
    chk("rst_busy", int'(Busy), 0);
    chk("rst_out_valid", int'(Out_valid), 0);
    chk("rst_out", int'(Out), 0);
    chk("rst_rate", int'(Rate), 0);
    chk("rst_length", int'(Length), 0);
    chk("rst_seed", int'(Descr_seed), 0);
    chk("rst_sig_err", int'(Signal_err), 0);
    chk("rst_frame_done", int'(Frame_done), 0);
    idle(2);

    run_frame("good",        4'b1101, 12'd3, 0, 0, 6'd0, 7'h5D, 0, 0, -1, 1);
    run_frame("parity_bad",  4'b1011, 12'd5, 1, 0, 6'd0, 7'h12, 0, 0, -1, 0);
    run_frame("rate_b3_0",   4'b0101, 12'd3, 0, 0, 6'd0, 7'h12, 0, 0, -1, 0);
    run_frame("len_zero",    4'b1101, 12'd0, 0, 0, 6'd0, 7'h12, 0, 0, -1, 0);
    run_frame("reserved",    4'b1101, 12'd3, 0, 1, 6'd0, 7'h12, 0, 0, -1, 0);
    run_frame("broken_pre",  4'b1001, 12'd1, 0, 0, 6'd0, 7'h2A, 0, 1, -1, 1);
    run_frame("gapped",      4'b1101, 12'd3, 0, 0, 6'd0, 7'h5D, 1, 0, -1, 1);
    run_frame("en_abort",    4'b1111, 12'd2, 0, 0, 6'd0, 7'h33, 0, 0, 10, 1);
`ifdef RX_SIGNAL_TAIL_CHECK_EN
    tail_ok = 0;
`else
    tail_ok = 1;
`endif
    run_frame("tail_bit",    4'b1100, 12'd1, 0, 0, 6'b000001, 7'h41, 0, 0, -1, tail_ok);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
